// File: rtl/alu_rs_scheduler_pkg.sv
// Shared ALU encodings, ROB tag width and station depth for the integer reservation station.
// The build option ALU_RS_AGE_SEL_EN is consumed by alu_rs_scheduler.sv.
package alu_rs_scheduler_pkg;

  localparam int ROB_SIZE_WIDTH = 4;
  localparam int RS_DEPTH_DEF   = 8;

  typedef enum logic [2:0] {
    ALU_ADD_SUB = 3'b000,
    ALU_SLL     = 3'b001,
    ALU_SLT     = 3'b010,
    ALU_SLTU    = 3'b011,
    ALU_XOR     = 3'b100,
    ALU_SRL_SRA = 3'b101,
    ALU_OR      = 3'b110,
    ALU_AND     = 3'b111
  } alu_op_l1_e;

  localparam logic ALU_L2_ADD = 1'b0;
  localparam logic ALU_L2_SUB = 1'b1;
  localparam logic ALU_L2_SRL = 1'b0;
  localparam logic ALU_L2_SRA = 1'b1;

  function automatic logic tag_hit(input logic                      cdb_ready,
                                   input logic [ROB_SIZE_WIDTH-1:0] cdb_tag,
                                   input logic [ROB_SIZE_WIDTH-1:0] tag);
    return cdb_ready && (cdb_tag == tag);
  endfunction

endpackage

// File: rtl/alu_rs_scheduler_rs_pick_lowest.sv
// Combinational priority encoder: reports whether any request bit is set and the lowest set index.
module rs_pick_lowest #(
  parameter  int N  = 8,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  output logic          found,
  output logic [IW-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/alu_rs_scheduler.sv
// Integer ALU reservation station: holds dispatched micro-ops, snoops ALU/LSB CDBs, issues one op per cycle.
// Build option ALU_RS_AGE_SEL_EN: issue the oldest ready entry instead of the lowest-index one.
module alu_rs_scheduler
  import alu_rs_scheduler_pkg::*;
#(
  parameter int RS_DEPTH = RS_DEPTH_DEF,
  parameter int ROB_W    = ROB_SIZE_WIDTH
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             need_flush_in,
  input  logic             disp_valid,
  input  logic [2:0]       disp_op_L1,
  input  logic             disp_op_L2,
  input  logic [31:0]      disp_vj,
  input  logic [31:0]      disp_vk,
  input  logic             disp_qj_valid,
  input  logic             disp_qk_valid,
  input  logic [ROB_W-1:0] disp_qj,
  input  logic [ROB_W-1:0] disp_qk,
  input  logic [ROB_W-1:0] disp_rob_id,
  output logic             full_out,
  input  logic             alu_cdb_ready,
  input  logic [31:0]      alu_cdb_value,
  input  logic [ROB_W-1:0] alu_cdb_rob_id,
  input  logic             lsb_cdb_ready,
  input  logic [31:0]      lsb_cdb_value,
  input  logic [ROB_W-1:0] lsb_cdb_rob_id,
  output logic             alu_valid,
  output logic [31:0]      alu_opr1,
  output logic [31:0]      alu_opr2,
  output logic [2:0]       alu_op_L1,
  output logic             alu_op_L2,
  output logic [ROB_W-1:0] alu_rob_id
);

  localparam int IDX_W = $clog2(RS_DEPTH);

  logic [RS_DEPTH-1:0] busy_vec, qj_pend_vec, qk_pend_vec, ready_vec, free_vec;
  alu_op_l1_e          op_l1_arr  [RS_DEPTH];
  logic                op_l2_arr  [RS_DEPTH];
  logic [31:0]         vj_arr     [RS_DEPTH];
  logic [31:0]         vk_arr     [RS_DEPTH];
  logic [ROB_W-1:0]    rob_id_arr [RS_DEPTH];
`ifdef ALU_RS_AGE_SEL_EN
  logic [IDX_W-1:0]    age_arr    [RS_DEPTH];
  logic [IDX_W-1:0]    best_age;
`endif

  logic             free_found, issue_found;
  logic [IDX_W-1:0] free_idx, issue_idx;
  logic             run, do_disp;
  logic [31:0]      disp_vj_next, disp_vk_next;
  logic             disp_qj_next, disp_qk_next;

  assign run       = rdy_in && !need_flush_in;
  assign full_out  = &busy_vec;
  assign free_vec  = ~busy_vec;
  assign ready_vec = busy_vec & ~qj_pend_vec & ~qk_pend_vec;
  assign do_disp   = run && disp_valid && free_found;

  // A producer broadcasting in the dispatch cycle would otherwise be missed forever.
  always_comb begin
    disp_vj_next = disp_vj;
    disp_qj_next = disp_qj_valid;
    disp_vk_next = disp_vk;
    disp_qk_next = disp_qk_valid;
    if (disp_qj_valid && tag_hit(alu_cdb_ready, alu_cdb_rob_id, disp_qj)) begin
      disp_vj_next = alu_cdb_value;
      disp_qj_next = 1'b0;
    end else if (disp_qj_valid && tag_hit(lsb_cdb_ready, lsb_cdb_rob_id, disp_qj)) begin
      disp_vj_next = lsb_cdb_value;
      disp_qj_next = 1'b0;
    end
    if (disp_qk_valid && tag_hit(alu_cdb_ready, alu_cdb_rob_id, disp_qk)) begin
      disp_vk_next = alu_cdb_value;
      disp_qk_next = 1'b0;
    end else if (disp_qk_valid && tag_hit(lsb_cdb_ready, lsb_cdb_rob_id, disp_qk)) begin
      disp_vk_next = lsb_cdb_value;
      disp_qk_next = 1'b0;
    end
  end

  rs_pick_lowest #(.N(RS_DEPTH)) u_pick_free (
    .req   (free_vec),
    .found (free_found),
    .idx   (free_idx)
  );

`ifdef ALU_RS_AGE_SEL_EN
  // Strict greater-than keeps the lowest index on equal ages.
  always_comb begin
    issue_found = 1'b0;
    issue_idx   = '0;
    best_age    = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (ready_vec[i] && (!issue_found || age_arr[i] > best_age)) begin
        issue_found = 1'b1;
        issue_idx   = IDX_W'(i);
        best_age    = age_arr[i];
      end
    end
  end
`else
  rs_pick_lowest #(.N(RS_DEPTH)) u_pick_ready (
    .req   (ready_vec),
    .found (issue_found),
    .idx   (issue_idx)
  );
`endif

  genvar gi;
  generate
    for (gi = 0; gi < RS_DEPTH; gi++) begin : g_entry
      logic             busy_reg, qj_valid_reg, qk_valid_reg, op_l2_reg;
      alu_op_l1_e       op_l1_reg;
      logic [31:0]      vj_reg, vk_reg;
      logic [ROB_W-1:0] qj_reg, qk_reg, rob_id_reg;
      logic             disp_here, issue_here;

      assign disp_here  = do_disp && (free_idx == IDX_W'(gi));
      assign issue_here = run && issue_found && (issue_idx == IDX_W'(gi));

      always_ff @(posedge clk_in) begin
        if (rst_in) begin
          busy_reg     <= 1'b0;
          qj_valid_reg <= 1'b0;
          qk_valid_reg <= 1'b0;
          op_l1_reg    <= ALU_ADD_SUB;
          op_l2_reg    <= ALU_L2_ADD;
          vj_reg       <= '0;
          vk_reg       <= '0;
          qj_reg       <= '0;
          qk_reg       <= '0;
          rob_id_reg   <= '0;
        end else if (rdy_in) begin
          if (need_flush_in) begin
            busy_reg     <= 1'b0;
            qj_valid_reg <= 1'b0;
            qk_valid_reg <= 1'b0;
          end else if (disp_here) begin
            busy_reg     <= 1'b1;
            op_l1_reg    <= alu_op_l1_e'(disp_op_L1);
            op_l2_reg    <= disp_op_L2;
            vj_reg       <= disp_vj_next;
            vk_reg       <= disp_vk_next;
            qj_valid_reg <= disp_qj_next;
            qk_valid_reg <= disp_qk_next;
            qj_reg       <= disp_qj;
            qk_reg       <= disp_qk;
            rob_id_reg   <= disp_rob_id;
          end else begin
            if (issue_here) busy_reg <= 1'b0;
            if (busy_reg && qj_valid_reg) begin
              if (tag_hit(alu_cdb_ready, alu_cdb_rob_id, qj_reg)) begin
                vj_reg       <= alu_cdb_value;
                qj_valid_reg <= 1'b0;
              end else if (tag_hit(lsb_cdb_ready, lsb_cdb_rob_id, qj_reg)) begin
                vj_reg       <= lsb_cdb_value;
                qj_valid_reg <= 1'b0;
              end
            end
            if (busy_reg && qk_valid_reg) begin
              if (tag_hit(alu_cdb_ready, alu_cdb_rob_id, qk_reg)) begin
                vk_reg       <= alu_cdb_value;
                qk_valid_reg <= 1'b0;
              end else if (tag_hit(lsb_cdb_ready, lsb_cdb_rob_id, qk_reg)) begin
                vk_reg       <= lsb_cdb_value;
                qk_valid_reg <= 1'b0;
              end
            end
          end
        end
      end

`ifdef ALU_RS_AGE_SEL_EN
      logic [IDX_W-1:0] age_reg;
      always_ff @(posedge clk_in) begin
        if (rst_in) begin
          age_reg <= '0;
        end else if (rdy_in) begin
          if (need_flush_in || disp_here) age_reg <= '0;
          else if (do_disp && busy_reg && (age_reg != '1)) age_reg <= age_reg + 1'b1;
        end
      end
      assign age_arr[gi] = age_reg;
`endif

      assign busy_vec[gi]    = busy_reg;
      assign qj_pend_vec[gi] = qj_valid_reg;
      assign qk_pend_vec[gi] = qk_valid_reg;
      assign op_l1_arr[gi]   = op_l1_reg;
      assign op_l2_arr[gi]   = op_l2_reg;
      assign vj_arr[gi]      = vj_reg;
      assign vk_arr[gi]      = vk_reg;
      assign rob_id_arr[gi]  = rob_id_reg;
    end
  endgenerate

  // Data outputs hold their last issued bundle when nothing issues.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      alu_valid  <= 1'b0;
      alu_opr1   <= '0;
      alu_opr2   <= '0;
      alu_op_L1  <= ALU_ADD_SUB;
      alu_op_L2  <= ALU_L2_ADD;
      alu_rob_id <= '0;
    end else if (run && issue_found) begin
      alu_valid  <= 1'b1;
      alu_opr1   <= vj_arr[issue_idx];
      alu_opr2   <= vk_arr[issue_idx];
      alu_op_L1  <= op_l1_arr[issue_idx];
      alu_op_L2  <= op_l2_arr[issue_idx];
      alu_rob_id <= rob_id_arr[issue_idx];
    end else begin
      alu_valid  <= 1'b0;
    end
  end

  // Dispatching into a full station drops the op; that is a dispatch-side bug.
  assert property (@(posedge clk_in) disable iff (rst_in)
                   !(rdy_in && !need_flush_in && disp_valid && full_out));

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Scoreboard bench for alu_rs_scheduler; expected issue order follows ALU_RS_AGE_SEL_EN when defined.
module tb_alu_rs_scheduler;
  import alu_rs_scheduler_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        need_flush_in = 1'b0;
  logic        disp_valid = 1'b0;
  logic [2:0]  disp_op_L1 = '0;
  logic        disp_op_L2 = 1'b0;
  logic [31:0] disp_vj = '0, disp_vk = '0;
  logic        disp_qj_valid = 1'b0, disp_qk_valid = 1'b0;
  logic [3:0]  disp_qj = '0, disp_qk = '0, disp_rob_id = '0;
  logic        full_out;
  logic        alu_cdb_ready = 1'b0, lsb_cdb_ready = 1'b0;
  logic [31:0] alu_cdb_value = '0, lsb_cdb_value = '0;
  logic [3:0]  alu_cdb_rob_id = '0, lsb_cdb_rob_id = '0;
  logic        alu_valid;
  logic [31:0] alu_opr1, alu_opr2;
  logic [2:0]  alu_op_L1;
  logic        alu_op_L2;
  logic [3:0]  alu_rob_id;

  int n_vec = 0;
  int n_err = 0;
  int issue_cnt = 0;
  int base;
  logic [71:0] exp_q[$];

  alu_rs_scheduler #(.RS_DEPTH(8), .ROB_W(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .need_flush_in(need_flush_in),
    .disp_valid(disp_valid), .disp_op_L1(disp_op_L1), .disp_op_L2(disp_op_L2),
    .disp_vj(disp_vj), .disp_vk(disp_vk), .disp_qj_valid(disp_qj_valid),
    .disp_qk_valid(disp_qk_valid), .disp_qj(disp_qj), .disp_qk(disp_qk),
    .disp_rob_id(disp_rob_id), .full_out(full_out),
    .alu_cdb_ready(alu_cdb_ready), .alu_cdb_value(alu_cdb_value), .alu_cdb_rob_id(alu_cdb_rob_id),
    .lsb_cdb_ready(lsb_cdb_ready), .lsb_cdb_value(lsb_cdb_value), .lsb_cdb_rob_id(lsb_cdb_rob_id),
    .alu_valid(alu_valid), .alu_opr1(alu_opr1), .alu_opr2(alu_opr2),
    .alu_op_L1(alu_op_L1), .alu_op_L2(alu_op_L2), .alu_rob_id(alu_rob_id)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_value(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  function automatic logic [71:0] pack_exp(input logic [2:0] op1, input logic op2,
                                           input logic [3:0] rob, input logic [31:0] o1,
                                           input logic [31:0] o2);
    return {op1, op2, rob, o1, o2};
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    disp_valid    = 1'b0;
    alu_cdb_ready = 1'b0;
    lsb_cdb_ready = 1'b0;
  endtask

  task automatic put_disp(input logic [2:0] op1, input logic op2, input logic [31:0] vj,
                          input logic [31:0] vk, input logic qjv, input logic [3:0] qj,
                          input logic qkv, input logic [3:0] qk, input logic [3:0] rob);
    disp_valid = 1'b1; disp_op_L1 = op1; disp_op_L2 = op2;
    disp_vj = vj; disp_vk = vk;
    disp_qj_valid = qjv; disp_qj = qj; disp_qk_valid = qkv; disp_qk = qk;
    disp_rob_id = rob;
  endtask

  task automatic alu_bcast(input logic [3:0] rob, input logic [31:0] val);
    alu_cdb_ready = 1'b1; alu_cdb_rob_id = rob; alu_cdb_value = val;
  endtask

  task automatic lsb_bcast(input logic [3:0] rob, input logic [31:0] val);
    lsb_cdb_ready = 1'b1; lsb_cdb_rob_id = rob; lsb_cdb_value = val;
  endtask

  // Every issue strobe is checked against the head of the scoreboard.
  always @(negedge clk_in) begin
    if (!rst_in && alu_valid) begin
      issue_cnt++;
      if (exp_q.size() == 0)
        check_value("issue_with_empty_sb", 72'(exp_q.size()), 72'd1);
      else
        check_value("issue", {alu_op_L1, alu_op_L2, alu_rob_id, alu_opr1, alu_opr2},
                    exp_q.pop_front());
    end
  end

  initial begin
    tick(); tick();
    rst_in = 1'b0;
    check_value("rst_valid", 72'(alu_valid), 72'd0);
    check_value("rst_bundle", {alu_op_L1, alu_op_L2, alu_rob_id, alu_opr1, alu_opr2}, 72'd0);
    check_value("rst_full", 72'(full_out), 72'd0);

    // Ready ADD: latency
    put_disp(ALU_ADD_SUB, ALU_L2_ADD, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
    exp_q.push_back(pack_exp(ALU_ADD_SUB, ALU_L2_ADD, 4'd3, 32'd5, 32'd7));
    tick(); idle();
    check_value("lat_t_valid", 72'(alu_valid), 72'd0);
    tick();
    check_value("lat_t1_valid", 72'(alu_valid), 72'd1);

    // SUB waiting on rob 2, woken by the ALU CDB
    put_disp(ALU_ADD_SUB, ALU_L2_SUB, 32'hDEAD, 32'd1, 1'b1, 4'd2, 1'b0, 4'd0, 4'd5);
    tick(); idle();
    base = issue_cnt;
    tick(); tick();
    check_value("no_issue_pending", 72'(issue_cnt), 72'(base));
    alu_bcast(4'd2, 32'd10);
    exp_q.push_back(pack_exp(ALU_ADD_SUB, ALU_L2_SUB, 4'd5, 32'd10, 32'd1));
    tick(); idle();
    check_value("no_same_cycle_wake", 72'(alu_valid), 72'd0);
    tick();
    check_value("wake_issue_valid", 72'(alu_valid), 72'd1);

    // Dispatch-time forwarding from the LSB CDB
    lsb_bcast(4'd6, 32'hFFFF_FFFF);
    put_disp(ALU_XOR, 1'b0, 32'h1234, 32'h0, 1'b0, 4'd0, 1'b1, 4'd6, 4'd7);
    exp_q.push_back(pack_exp(ALU_XOR, 1'b0, 4'd7, 32'h1234, 32'hFFFF_FFFF));
    tick(); idle();
    tick();
    check_value("fwd_issue_valid", 72'(alu_valid), 72'd1);

    // Fill all eight entries pending on tags 8..15
    for (int i = 0; i < 8; i++) begin
      put_disp(ALU_OR, 1'b0, 32'h100 + i, 32'h200 + i, 1'b1, 4'(8 + i), 1'b0, 4'd0, 4'(i));
      tick();
    end
    idle();
    check_value("full_set", 72'(full_out), 72'd1);
    base = issue_cnt;
    tick();
    check_value("no_issue_full_pending", 72'(issue_cnt), 72'(base));
    alu_bcast(4'd12, 32'h44);
    exp_q.push_back(pack_exp(ALU_OR, 1'b0, 4'd4, 32'h44, 32'h204));
    tick(); idle();
    check_value("full_hold_wake", 72'(full_out), 72'd1);
    tick();
    check_value("entry4_issue_valid", 72'(alu_valid), 72'd1);
    check_value("full_drop", 72'(full_out), 72'd0);
    // New ready op refills slot 4 while entry 5 wakes in the same cycle
    put_disp(ALU_ADD_SUB, ALU_L2_ADD, 32'h99, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9);
    alu_bcast(4'd13, 32'h55);
`ifdef ALU_RS_AGE_SEL_EN
    exp_q.push_back(pack_exp(ALU_OR, 1'b0, 4'd5, 32'h55, 32'h205));
    exp_q.push_back(pack_exp(ALU_ADD_SUB, ALU_L2_ADD, 4'd9, 32'h99, 32'd1));
`else
    exp_q.push_back(pack_exp(ALU_ADD_SUB, ALU_L2_ADD, 4'd9, 32'h99, 32'd1));
    exp_q.push_back(pack_exp(ALU_OR, 1'b0, 4'd5, 32'h55, 32'h205));
`endif
    tick(); idle();
    check_value("refill_full", 72'(full_out), 72'd1);
    tick(); tick(); tick();
    need_flush_in = 1'b1;
    tick(); need_flush_in = 1'b0;
    check_value("flush_full_clear", 72'(full_out), 72'd0);

    // Four entries woken together, flushed before any issues
    for (int i = 0; i < 4; i++) begin
      put_disp(ALU_SLT, 1'b0, 32'h300 + i, 32'h400 + i, (i < 2), 4'd10, (i >= 2), 4'd11, 4'(i));
      tick();
    end
    idle();
    base = issue_cnt;
    alu_bcast(4'd10, 32'hA0);
    lsb_bcast(4'd11, 32'hB0);
    tick(); idle();
    need_flush_in = 1'b1;
    put_disp(ALU_ADD_SUB, ALU_L2_ADD, 32'd5, 32'd6, 1'b0, 4'd0, 1'b0, 4'd0, 4'd8);
    tick(); idle(); need_flush_in = 1'b0;
    check_value("flush_valid_low", 72'(alu_valid), 72'd0);
    check_value("flush_full_low", 72'(full_out), 72'd0);
    tick(); tick(); tick();
    check_value("no_issue_after_flush", 72'(issue_cnt), 72'(base));
    put_disp(ALU_SRL_SRA, ALU_L2_SRA, 32'h8000_0000, 32'd4, 1'b0, 4'd0, 1'b0, 4'd0, 4'd10);
    exp_q.push_back(pack_exp(ALU_SRL_SRA, ALU_L2_SRA, 4'd10, 32'h8000_0000, 32'd4));
    tick(); idle();
    tick();
    check_value("post_flush_issue", 72'(alu_valid), 72'd1);

    // Stall: slots end up B(0) A(1) C(2) D(3), dispatch order A,B,C,D
    put_disp(ALU_ADD_SUB, ALU_L2_ADD, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0);
    exp_q.push_back(pack_exp(ALU_ADD_SUB, ALU_L2_ADD, 4'd0, 32'd1, 32'd2));
    tick();
    put_disp(ALU_AND, 1'b0, 32'd0, 32'hA, 1'b1, 4'd12, 1'b0, 4'd0, 4'd1); tick();
    put_disp(ALU_AND, 1'b0, 32'd0, 32'hB, 1'b1, 4'd12, 1'b0, 4'd0, 4'd2); tick();
    put_disp(ALU_AND, 1'b0, 32'd0, 32'hC, 1'b1, 4'd12, 1'b0, 4'd0, 4'd3); tick();
    put_disp(ALU_OR, 1'b0, 32'hD, 32'd0, 1'b0, 4'd0, 1'b1, 4'd13, 4'd4); tick();
    idle();
    alu_bcast(4'd12, 32'h55);
    tick(); idle();
    rdy_in = 1'b0;
    alu_bcast(4'd13, 32'h77);
    for (int k = 0; k < 3; k++) begin
      tick(); idle();
      check_value("stall_valid_low", 72'(alu_valid), 72'd0);
    end
    base = issue_cnt;
`ifdef ALU_RS_AGE_SEL_EN
    exp_q.push_back(pack_exp(ALU_AND, 1'b0, 4'd1, 32'h55, 32'hA));
    exp_q.push_back(pack_exp(ALU_AND, 1'b0, 4'd2, 32'h55, 32'hB));
`else
    exp_q.push_back(pack_exp(ALU_AND, 1'b0, 4'd2, 32'h55, 32'hB));
    exp_q.push_back(pack_exp(ALU_AND, 1'b0, 4'd1, 32'h55, 32'hA));
`endif
    exp_q.push_back(pack_exp(ALU_AND, 1'b0, 4'd3, 32'h55, 32'hC));
    rdy_in = 1'b1;
    tick(); tick(); tick(); tick();
    check_value("resume_issue_cnt", 72'(issue_cnt), 72'(base + 3));
    lsb_bcast(4'd13, 32'h88);
    exp_q.push_back(pack_exp(ALU_OR, 1'b0, 4'd4, 32'hD, 32'h88));
    tick(); idle();
    tick();
    check_value("late_wake_valid", 72'(alu_valid), 72'd1);
    tick(); tick();
    check_value("sb_empty", 72'(exp_q.size()), 72'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
